// File: rtl/fp_pkg.sv
// Shared floating-point types for the Vector ALU: operand class, unpacked operand,
// exception flags and the canonical quiet-NaN encoding for any exponent/mantissa width.
package fp_pkg;

    // Widest format the unpacked struct can carry (IEEE double)
    localparam int FP_MAX_EXP_W = 11;
    localparam int FP_MAX_SIG_W = 53;
    localparam int FP_MAX_W     = 64;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

    typedef struct packed {
        logic                    sign;
        logic [FP_MAX_EXP_W-1:0] exp;
        logic [FP_MAX_SIG_W-1:0] sig;
    } fp_unpacked_t;

    typedef struct packed {
        logic nan;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] one;
        one     = FP_MAX_W'(1);
        fp_qnan = (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter  int WIDTH = 28,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    // NOTE: a combinational block must assign every output before any conditional
    // update, otherwise the tool infers a latch to hold the old value.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/float_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with valid/ready streaming,
// round-to-nearest-even, flush-to-zero and a sideband tag per operation.
module float_addsub_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    parameter  int TAG_W = 4,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nan,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact
);

    localparam int SW      = MAN_W + 1;        // significand incl. hidden bit
    localparam int EW      = SW + 3;           // plus guard, round, sticky
    localparam int SUM_W   = EW + 1;           // plus carry
    localparam int LZ_W    = $clog2(SUM_W + 1);
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));

    typedef struct packed {
        logic         hit;
        logic [W-1:0] word;
        fp_flags_t    flags;
    } special_t;

    function automatic fp_class_t classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        e = x[W-2 -: EXP_W];
        if (e == EXP_ONES)  classify = (x[MAN_W-1:0] != '0) ? NAN : INF;
        else if (e == '0)   classify = ZERO;
        else                classify = NORM;
    endfunction

    // Denormals collapse to a signed zero here
    function automatic fp_unpacked_t unpack(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        e           = x[W-2 -: EXP_W];
        unpack.sign = x[W-1];
        if (e == '0) begin
            unpack.exp = '0;
            unpack.sig = '0;
        end else begin
            unpack.exp = FP_MAX_EXP_W'(e);
            unpack.sig = FP_MAX_SIG_W'({1'b1, x[MAN_W-1:0]});
        end
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack / classify / swap ----------------
    logic [W-1:0] b_eff;
    fp_class_t    a_cls, b_cls;
    fp_unpacked_t a_op, b_op;
    logic         swap;
    special_t     s1_spec_d;

    always_comb begin
        b_eff     = {in_b[W-1] ^ in_sub, in_b[W-2:0]};
        a_cls     = classify(in_a);
        b_cls     = classify(b_eff);
        a_op      = unpack(in_a);
        b_op      = unpack(b_eff);
        swap      = (b_cls == NORM) && ((a_cls == ZERO) || (b_eff[W-2:0] > in_a[W-2:0]));
        s1_spec_d = '0;
        if (a_cls == NAN || b_cls == NAN ||
            (a_cls == INF && b_cls == INF && in_a[W-1] != b_eff[W-1])) begin
            s1_spec_d.hit       = 1'b1;
            s1_spec_d.word      = QNAN;
            s1_spec_d.flags.nan = 1'b1;
        end else if (a_cls == INF) begin
            s1_spec_d.hit  = 1'b1;
            s1_spec_d.word = {in_a[W-1], EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_cls == INF) begin
            s1_spec_d.hit  = 1'b1;
            s1_spec_d.word = {b_eff[W-1], EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic             s1_valid, s2_valid, s3_valid;
    logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
    special_t         s1_spec, s2_spec, s3_spec;
    logic             s1_eff_sub, s2_eff_sub, s3_eff_sub;
    fp_unpacked_t     s1_big, s1_small;

    // ---------------- S2: align ----------------
    logic [EXP_W-1:0] exp_diff;
    logic [EW-1:0]    small_ext, lost_mask, small_aligned;

    always_comb begin
        exp_diff  = s1_big.exp[EXP_W-1:0] - s1_small.exp[EXP_W-1:0];
        small_ext = {s1_small.sig[MAN_W:0], 3'b000};
        lost_mask = (EW'(1) << exp_diff) - EW'(1);
        if (int'(exp_diff) >= MAN_W + 3)
            small_aligned = EW'(small_ext != '0);
        else
            small_aligned = (small_ext >> exp_diff) | EW'((small_ext & lost_mask) != '0);
    end

    logic             s2_sign;
    logic [EXP_W-1:0] s2_exp;
    logic [EW-1:0]    s2_big, s2_small;

    // ---------------- S3: add ----------------
    logic [SUM_W-1:0] sum_d;

    always_comb begin
        if (s2_eff_sub) sum_d = {1'b0, s2_big} - {1'b0, s2_small};
        else            sum_d = {1'b0, s2_big} + {1'b0, s2_small};
    end

    logic             s3_sign;
    logic [EXP_W-1:0] s3_exp;
    logic [SUM_W-1:0] s3_sum;

    // ---------------- S4: normalise / round / pack ----------------
    logic [LZ_W-1:0]  lz;
    logic [SUM_W-1:0] norm;
    logic [SW-1:0]    kept;
    logic             guard_bit, sticky_bit, round_up;
    logic [SW:0]      rounded;
    int               exp_adj;
    logic [W-1:0]     res_d;
    fp_flags_t        flags_d;

    fp_lzc #(.WIDTH(SUM_W)) u_lzc (
        .data  (s3_sum),
        .count (lz)
    );

    always_comb begin
        norm       = s3_sum << lz;
        kept       = norm[SUM_W-1 -: SW];
        guard_bit  = norm[3];
        sticky_bit = |norm[2:0];
        round_up   = guard_bit & (sticky_bit | kept[0]);
        rounded    = {1'b0, kept} + (SW + 1)'(round_up);
        // Carry position sits one above the operand exponent; a rounding carry adds one more
        exp_adj    = int'(s3_exp) + 1 - int'(lz) + int'(rounded[SW]);
        res_d      = '0;
        flags_d    = '0;
        if (s3_spec.hit) begin
            res_d   = s3_spec.word;
            flags_d = s3_spec.flags;
        end else if (s3_sum == '0) begin
            res_d = {s3_sign & ~s3_eff_sub, {(W-1){1'b0}}};
        end else if (exp_adj >= EXP_MAX) begin
            res_d             = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
            flags_d.overflow  = 1'b1;
            flags_d.inexact   = 1'b1;
        end else if (exp_adj < 1) begin
            res_d             = {s3_sign, {(W-1){1'b0}}};
            flags_d.underflow = 1'b1;
            flags_d.inexact   = 1'b1;
        end else begin
            // After a rounding carry the fraction bits are all zero, so no re-shift is needed
            res_d           = {s3_sign, EXP_W'(exp_adj), rounded[MAN_W-1:0]};
            flags_d.inexact = guard_bit | sticky_bit;
        end
    end

    fp_flags_t out_flags;
    assign out_nan       = out_flags.nan;
    assign out_overflow  = out_flags.overflow;
    assign out_underflow = out_flags.underflow;
    assign out_inexact   = out_flags.inexact;

    // ---------------- pipeline control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else if (adv) begin
            s1_valid   <= in_valid;
            s2_valid   <= s1_valid;
            s3_valid   <= s2_valid;
            out_valid  <= s3_valid;
            out_result <= res_d;
            out_tag    <= s3_tag;
            out_flags  <= flags_d;
        end
    end

    // NOTE: stage payload registers are deliberately left out of reset; the stage valid
    // bits gate them, so clearing the payload would add reset fan-out for no behaviour.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_tag     <= in_tag;
            s1_spec    <= s1_spec_d;
            s1_eff_sub <= in_a[W-1] ^ b_eff[W-1];
            s1_big     <= swap ? b_op : a_op;
            s1_small   <= swap ? a_op : b_op;

            s2_tag     <= s1_tag;
            s2_spec    <= s1_spec;
            s2_eff_sub <= s1_eff_sub;
            s2_sign    <= s1_big.sign;
            s2_exp     <= s1_big.exp[EXP_W-1:0];
            s2_big     <= {s1_big.sig[MAN_W:0], 3'b000};
            s2_small   <= small_aligned;

            s3_tag     <= s2_tag;
            s3_spec    <= s2_spec;
            s3_eff_sub <= s2_eff_sub;
            s3_sign    <= s2_sign;
            s3_exp     <= s2_exp;
            s3_sum     <= sum_d;
        end
    end

    // Upper bits of the wide unpacked struct and the post-round hidden bit carry no information
    logic unused_bits;
    assign unused_bits = ^{s1_big, s1_small, rounded};

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Directed self-checking bench for float_addsub_pipe: single precision plus a
// half-precision instance, with hand-computed expected words and flags.
module tb_float_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_sub, out_ready;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;

    logic        in_ready, out_valid, out_nan, out_overflow, out_underflow, out_inexact;
    logic [31:0] out_result;
    logic [3:0]  out_tag;

    logic        h_in_ready, h_out_valid, h_out_nan, h_out_overflow, h_out_underflow, h_out_inexact;
    logic [15:0] h_out_result;
    logic [3:0]  h_out_tag;

    int         checks  = 0;
    int         errors  = 0;
    logic [3:0] tag_ctr = 4'd0;

    always #5 clk = ~clk;

    float_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_nan(out_nan), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .out_inexact(out_inexact)
    );

    float_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_half (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(h_in_ready),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(h_out_valid), .out_ready(out_ready),
        .out_result(h_out_result), .out_tag(h_out_tag),
        .out_nan(h_out_nan), .out_overflow(h_out_overflow),
        .out_underflow(h_out_underflow), .out_inexact(h_out_inexact)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One operation through an idle pipeline; flags ordered {nan, overflow, underflow, inexact}
    task automatic run_op(input string name, input bit half,
                          input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags);
        int         lat;
        logic [3:0] tag;
        tag     = tag_ctr;
        tag_ctr = tag_ctr + 4'd1;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_tag    = tag;
        out_ready = 1'b1;
        #1;
        check({name, " in_ready"}, 32'(half ? h_in_ready : in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!(half ? h_out_valid : out_valid) && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd4);
        if (half) begin
            check({name, " result"}, {16'h0, h_out_result}, exp_res);
            check({name, " flags"},
                  32'({h_out_nan, h_out_overflow, h_out_underflow, h_out_inexact}), 32'(exp_flags));
            check({name, " tag"}, 32'(h_out_tag), 32'(tag));
        end else begin
            check({name, " result"}, out_result, exp_res);
            check({name, " flags"},
                  32'({out_nan, out_overflow, out_underflow, out_inexact}), 32'(exp_flags));
            check({name, " tag"}, 32'(out_tag), 32'(tag));
        end
    endtask

    // Eight back-to-back ops (k + 1.0) with the consumer stalled for stream cycles 5..9
    task automatic stream_test();
        logic [31:0] vals [9];
        int          sent;
        int          rcvd;
        vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 40 && rcvd < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 9);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_a   = vals[sent];
                in_b   = 32'h3F800000;
                in_sub = 1'b0;
                in_tag = 4'(sent);
            end
            #1;
            check("bp in_ready", 32'(in_ready), 32'(!(c >= 5 && c <= 9)));
            if (out_valid) begin
                check("bp tag", 32'(out_tag), 32'(rcvd));
                check("bp result", out_result, vals[rcvd + 1]);
                if (out_ready) rcvd++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("bp received", 32'(rcvd), 32'd8);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            #1;
            check("bp drained", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_tag", 32'(out_tag), 32'd0);
        check("reset flags", 32'({out_nan, out_overflow, out_underflow, out_inexact}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        run_op("1+2",         1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        run_op("1-2",         1'b0, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
        run_op("1-0.5",       1'b0, 32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'b0000);
        run_op("inf+-inf",    1'b0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("inf-inf",     1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
        run_op("-inf+denorm", 1'b0, 32'hFF800000, 32'h000005F3, 1'b0, 32'hFF800000, 4'b0000);
        run_op("nan+1",       1'b0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("max+max",     1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        run_op("underflow",   1'b0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
        run_op("3-3",         1'b0, 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000);
        run_op("-0+-0",       1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        run_op("+0+-0",       1'b0, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
        run_op("tie even",    1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        run_op("tie odd",     1'b0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        run_op("sticky only", 1'b0, 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'b0001);

        stream_test();

        // Reset with three operations in flight
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h40000000;
            in_b     = 32'h40000000;
            in_sub   = 1'b0;
            in_tag   = 4'(i + 8);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("flight reset result", out_result, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("flight reset out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        run_op("1+1 after reset", 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);

        run_op("half 1+1",       1'b1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 4'b0000);
        run_op("half max+max",   1'b1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 4'b0101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
